// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encodings and grant IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle watchdog for mem_port_arbiter: cleared on grant, counts while BUSY,
// flags expire in the TIMEOUT_CYC-th BUSY cycle. TIMEOUT_CYC must be >= 2.
module mem_arb_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (count && !expire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = count && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data load/store.
// Define MEM_ARB_TIMEOUT_EN to add the BUSY watchdog and a live err_timeout flag.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int DM_BURST_MAX = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_ren,
  input  logic              dm_wen,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err_timeout
);

  localparam int STREAK_W = $clog2(DM_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DM_BURST_MAX);

  arb_state_t          state;
  grant_t              gnt;
  logic [STREAK_W-1:0] dm_streak;

  logic              dm_req;
  logic              dm_blocked;
  logic              grant_dm;
  logic              grant_if;
  logic              busy_done;
  logic [DATA_W-1:0] done_rdata;

  assign dm_req     = dm_ren | dm_wen;
  // A saturated streak hands the next slot to a waiting fetch.
  assign dm_blocked = if_req && (dm_streak == STREAK_MAX);
  assign grant_dm   = (state == ARB_IDLE) && dm_req && !dm_blocked;
  assign grant_if   = (state == ARB_IDLE) && !grant_dm && if_req;

`ifdef MEM_ARB_TIMEOUT_EN
  logic wd_expire;

  mem_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .load  (grant_dm | grant_if),
    .count (state == ARB_BUSY),
    .expire(wd_expire)
  );

  // A real mem_ack wins over an expiry landing in the same cycle.
  assign busy_done  = mem_ack | wd_expire;
  assign done_rdata = mem_ack ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_timeout <= 1'b0;
    end else if (wd_expire && !mem_ack) begin
      err_timeout <= 1'b1;
    end
  end
`else
  assign busy_done   = mem_ack;
  assign done_rdata  = mem_rdata;
  assign err_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      gnt       <= GNT_IF;
      dm_streak <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      // NOTE: acks default low each cycle so they can only ever be one-cycle pulses.
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_dm) begin
            state     <= ARB_BUSY;
            gnt       <= GNT_DM;
            mem_req   <= 1'b1;
            mem_we    <= dm_wen;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            if (!if_req) begin
              dm_streak <= '0;
            end else if (dm_streak != STREAK_MAX) begin
              dm_streak <= dm_streak + 1'b1;
            end
          end else if (grant_if) begin
            state     <= ARB_BUSY;
            gnt       <= GNT_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            dm_streak <= '0;
          end else begin
            dm_streak <= '0;
          end
        end
        ARB_BUSY: begin
          if (busy_done) begin
            state   <= ARB_DONE;
            mem_req <= 1'b0;
            if (gnt == GNT_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= done_rdata;
            end else begin
              dm_ack <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= done_rdata;
              end
            end
          end
        end
        ARB_DONE: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter: one access per table row, plus
// hand-written sequences for stray acks, reset mid-access and (if enabled) the watchdog.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_ren;
  logic        dm_wen;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_ack     (if_ack),
    .dm_ren     (dm_ren),
    .dm_wen     (dm_wen),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_ack     (dm_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_ren;
    logic        dm_wen;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    int          mem_lat;       // BUSY cycles before mem_ack is driven
    logic [31:0] mem_rdata;
    logic        exp_dm;        // 1: DM expected to win this slot
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Applies one row's request levels in an IDLE cycle, plays the memory side, and
  // drops only the acked requester's request once its ack pulse has been seen.
  task automatic run_vec(input vec_t v);
    int n;
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    dm_ren   = v.dm_ren;
    dm_wen   = v.dm_wen;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
    n = 0;
    while (!mem_req && n < 8) begin
      tick();
      n++;
    end
    check({v.name, "/grant_lat"}, 32'(n), 32'd1);
    check({v.name, "/mem_we"}, 32'(mem_we), 32'(v.exp_we));
    check({v.name, "/mem_addr"}, mem_addr, v.exp_addr);
    if (v.exp_we) check({v.name, "/mem_wdata"}, mem_wdata, v.dm_wdata);
    repeat (v.mem_lat) tick();
    check({v.name, "/req_held"}, {31'd0, mem_req}, 32'd1);
    check({v.name, "/addr_stable"}, mem_addr, v.exp_addr);
    check({v.name, "/no_early_ack"}, {30'd0, if_ack, dm_ack}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = v.mem_rdata;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 32'hA5A5_A5A5;
    check({v.name, "/req_dropped"}, {31'd0, mem_req}, 32'd0);
    check({v.name, "/acks"}, {30'd0, if_ack, dm_ack}, v.exp_dm ? 32'd1 : 32'd2);
    check({v.name, "/if_rdata"}, if_rdata, v.exp_if_rdata);
    check({v.name, "/dm_rdata"}, dm_rdata, v.exp_dm_rdata);
    tick();
    check({v.name, "/ack_pulse"}, {30'd0, if_ack, dm_ack}, 32'd0);
    if (v.exp_dm) begin
      dm_ren = 1'b0;
      dm_wen = 1'b0;
    end else begin
      if_req = 1'b0;
    end
  endtask

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    logic seen_ack;

    //          name            ifq if_addr        ren  wen  dm_addr        dm_wdata       lat rdata          dm   we   exp_addr       exp_if_rdata   exp_dm_rdata
    vecs[0]  = '{"if_fetch",    1, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         32'h0,         1, 32'h2402_000A, 1'b0, 1'b0, 32'h0000_0100, 32'h2402_000A, 32'h0};
    vecs[1]  = '{"prio_dm",     1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         0, 32'h1111_2222, 1'b1, 1'b0, 32'h0000_0200, 32'h2402_000A, 32'h1111_2222};
    vecs[2]  = '{"prio_if",     1, 32'h0000_0104, 1'b0, 1'b0, 32'h0,         32'h0,         2, 32'h8C43_0004, 1'b0, 1'b0, 32'h0000_0104, 32'h8C43_0004, 32'h1111_2222};
    vecs[3]  = '{"burst_dm0",   1, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_0400, 32'hA000_0000, 0, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_0400, 32'h8C43_0004, 32'h1111_2222};
    vecs[4]  = '{"burst_dm1",   1, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_0404, 32'hA000_0001, 0, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_0404, 32'h8C43_0004, 32'h1111_2222};
    vecs[5]  = '{"burst_dm2",   1, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_0408, 32'hA000_0002, 1, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_0408, 32'h8C43_0004, 32'h1111_2222};
    vecs[6]  = '{"burst_dm3",   1, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_040C, 32'hA000_0003, 0, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_040C, 32'h8C43_0004, 32'h1111_2222};
    vecs[7]  = '{"burst_if",    1, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_0410, 32'hA000_0004, 1, 32'h0085_1020, 1'b0, 1'b0, 32'h0000_0108, 32'h0085_1020, 32'h1111_2222};
    vecs[8]  = '{"dm_after_if", 0, 32'h0000_0108, 1'b0, 1'b1, 32'h0000_0410, 32'hA000_0004, 1, 32'h4444_4444, 1'b1, 1'b1, 32'h0000_0410, 32'h0085_1020, 32'h1111_2222};
    vecs[9]  = '{"rw_both",     0, 32'h0000_0108, 1'b1, 1'b1, 32'h0000_0500, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_0500, 32'h0085_1020, 32'h1111_2222};
    vecs[10] = '{"dm_rd_slow",  0, 32'h0000_0108, 1'b1, 1'b0, 32'h0000_0504, 32'h0,         3, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_0504, 32'h0085_1020, 32'hCAFE_F00D};
    vecs[11] = '{"if_slow",     1, 32'h0000_010C, 1'b0, 1'b0, 32'h0,         32'h0,         4, 32'h1234_5678, 1'b0, 1'b0, 32'h0000_010C, 32'h1234_5678, 32'hCAFE_F00D};

    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_ren    = 1'b0;
    dm_wen    = 1'b0;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check("reset/mem_req", {31'd0, mem_req}, 32'd0);
    check("reset/mem_we", {31'd0, mem_we}, 32'd0);
    check("reset/mem_addr", mem_addr, 32'd0);
    check("reset/mem_wdata", mem_wdata, 32'd0);
    check("reset/acks", {30'd0, if_ack, dm_ack}, 32'd0);
    check("reset/if_rdata", if_rdata, 32'd0);
    check("reset/dm_rdata", dm_rdata, 32'd0);
    check("reset/err_timeout", {31'd0, err_timeout}, 32'd0);
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // mem_ack while IDLE must not start or complete anything.
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_0000;
    tick();
    mem_ack = 1'b0;
    check("stray_ack/mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    check("stray_ack/acks", {30'd0, if_ack, dm_ack}, 32'd0);
    check("stray_ack/if_rdata", if_rdata, 32'h1234_5678);
    check("stray_ack/dm_rdata", dm_rdata, 32'hCAFE_F00D);

`ifdef MEM_ARB_TIMEOUT_EN
    if_req  = 1'b1;
    if_addr = 32'h0000_0700;
    n = 0;
    while (!if_ack && n < 200) begin
      tick();
      n++;
    end
    check("timeout/ack_lat", 32'(n), 32'd65);
    check("timeout/if_rdata", if_rdata, 32'd0);
    check("timeout/mem_req", {31'd0, mem_req}, 32'd0);
    check("timeout/err", {31'd0, err_timeout}, 32'd1);
    tick();
    if_req = 1'b0;
    repeat (3) tick();
    check("timeout/err_sticky", {31'd0, err_timeout}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("timeout/err_cleared", {31'd0, err_timeout}, 32'd0);
    tick();
`else
    check("no_timeout/err_tied0", {31'd0, err_timeout}, 32'd0);
`endif

    // Reset in the middle of a BUSY access: no ack, every output back to 0.
    if_req  = 1'b1;
    if_addr = 32'h0000_0300;
    n = 0;
    while (!mem_req && n < 8) begin
      tick();
      n++;
    end
    check("rst_busy/granted", {31'd0, mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    if_req = 1'b0;
    check("rst_busy/mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_busy/mem_addr", mem_addr, 32'd0);
    check("rst_busy/if_rdata", if_rdata, 32'd0);
    check("rst_busy/dm_rdata", dm_rdata, 32'd0);
    check("rst_busy/err", {31'd0, err_timeout}, 32'd0);
    rst = 1'b0;
    seen_ack = 1'b0;
    mem_ack  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem_ack  = 1'b0;
      seen_ack = seen_ack | if_ack | dm_ack | mem_req;
    end
    check("rst_busy/no_ack", {31'd0, seen_ack}, 32'd0);

    v = '{"post_rst", 1, 32'h0000_0304, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 0, 32'h7777_8888,
          1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h7777_8888};
    run_vec(v);
    v = '{"post_rst_if", 1, 32'h0000_0304, 1'b0, 1'b0, 32'h0, 32'h0, 1, 32'h9999_AAAA,
          1'b0, 1'b0, 32'h0000_0304, 32'h9999_AAAA, 32'h7777_8888};
    run_vec(v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
